uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter: successor to the fixed 8-bit transmitter in the UART subsystem. It adds configurable data width, an internal baud-rate divider and one or two stop bits. Frame configuration is latched at frame acceptance, so inputs may change mid-frame without corrupting the frame in flight. It sits between the parallel-data producer and the serial line, driving the TX pin directly.

## Interface
Parameters:
- DATA_WIDTH, 8: data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range 1..65535.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- Data_Valid  input  1  request to send P_Data; a frame is accepted only when busy=0.
- P_Data  input  DATA_WIDTH  parallel data, sent LSB first.
- parity_enable  input  1  1 = insert parity bit after data.
- Parity_Type  input  1  0 = even, 1 = odd.
- stop_two  input  1  0 = one stop bit, 1 = two stop bits.
- busy  output  1  frame in progress; Data_Valid is ignored while high.
- TX_OUT  output  1  serial line; idle high.
- tx_done  output  1  one-cycle pulse on the last cycle of the final stop bit.

## Operation
- Reset (rst=0 at a clk edge): state IDLE, TX_OUT=1, busy=0, tx_done=0, all counters 0.
  - Applies mid-frame: the line returns high on that edge and the frame is abandoned.
- Acceptance: Data_Valid=1 while in IDLE. Latch all of the following into shadow registers:
  - P_Data;
  - the parity bit, computed as XOR of P_Data, inverted when Parity_Type=1;
  - parity_enable and stop_two.
- Inputs are don't-care after acceptance.
- States and transitions:
  - IDLE: TX_OUT=1. Goes to START on acceptance.
  - START: TX_OUT=0. Goes to DATA.
  - DATA: TX_OUT=shift[0], shifting right once per bit. Exits after DATA_WIDTH bits: to PARITY if the latched parity_enable=1, else to STOP.
  - PARITY: TX_OUT=latched parity bit. Goes to STOP.
  - STOP: TX_OUT=1. Lasts 1 or 2 bit periods per the latched stop_two, then returns to IDLE.
- Bit timing: a tick counter (width clog2(CLKS_PER_BIT), minimum 1) counts 0..CLKS_PER_BIT-1.
  - The bit advances when the counter reaches CLKS_PER_BIT-1; the counter then wraps to 0.
  - The counter is held at 0 in IDLE.
- Bit index counter, width clog2(DATA_WIDTH+1):
  - counts data bits in DATA;
  - is reused to count stop bits in STOP;
  - is cleared on every state change.
- Data_Valid while busy=1: ignored. There is no queue; the producer must hold Data_Valid or re-present it.
- TX_OUT is driven from a register; it must be glitch-free and carry no combinational path from any input.

## Timing
- Acceptance is at edge N (Data_Valid=1, IDLE). From edge N, TX_OUT=0 and busy=1.
- Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame length: (1 + DATA_WIDTH + P + S) × CLKS_PER_BIT cycles, where P = parity_enable (0/1) and S = 1 or 2.
- tx_done=1 during the last cycle of the final stop bit. On the next edge: state IDLE, busy=0.
- Back-to-back frames: Data_Valid held high is accepted in the first IDLE cycle.
  - The inter-frame gap is exactly one clk of idle-high beyond the stop bit(s).
- CLKS_PER_BIT=1: each state lasts one cycle and the same rules hold.
- Simultaneous events:
  - rst=0 overrides Data_Valid in the same cycle.
  - Config input changes in the acceptance cycle are captured; later changes are ignored.

## Structure
- Shared package uart_pkg holds:
  - the state enum tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - the constants PARITY_EVEN=0 and PARITY_ODD=1;
  - the constants IDLE_LEVEL=1 and START_LEVEL=0.
  - The future uart_rx imports the same package.
- One sub-module: uart_baud_tick. It holds the tick counter, takes CLKS_PER_BIT, has inputs clk/rst/enable, and outputs bit_tick. It is reusable by the receiver.
- The FSM, shift register, parity latch and output register stay in uart_tx_frame.

## Test plan
- Reset: assert rst=0 mid-frame (DATA state, CLKS_PER_BIT=4) -> next edge TX_OUT=1, busy=0, tx_done=0. No further transitions until Data_Valid.
- Even parity: DATA_WIDTH=8, CLKS_PER_BIT=4, P_Data=0xA5, parity_enable=1, Parity_Type=0, stop_two=0 -> line reads 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles, 44 cycles total. tx_done on cycle 44; busy low at cycle 45.
- Odd parity, two stop bits: same data with Parity_Type=1 and stop_two=1 -> parity bit=1, then 8 cycles of high stop. Frame is 48 cycles.
- Width and no parity: DATA_WIDTH=5, CLKS_PER_BIT=1, P_Data=5'b10011, parity_enable=0 -> line reads 0,1,1,0,0,1,1. busy is high for exactly 7 cycles.
- Back-to-back and ignore: hold Data_Valid=1 with 0x3C then 0xC3; pulse Data_Valid with 0xFF mid-frame -> 0xFF is never sent. The second frame's start bit begins exactly one cycle after the first frame's stop ends.
- Config stability: toggle P_Data, Parity_Type and stop_two every cycle after acceptance -> transmitted frame matches the acceptance-cycle values.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: line states, parity/level constants, parity helper.
// Imported by the transmitter and, later, the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Callers zero-extend narrower data; extra zero bits do not change the XOR.
  function automatic logic parity_bit(input logic [8:0] d, input logic ptype);
    return (^d) ^ (ptype == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: bit_tick on the last of every CLKS_PER_BIT enabled cycles.
// Latency: first tick CLKS_PER_BIT-1 cycles after enable rises; no backpressure, held at 0 while disabled.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!enable || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_tick = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_WIDTH bits LSB first, optional parity, 1 or 2 stops.
// Latency: start bit on the line from the accepting edge; Data_Valid ignored while busy (no queue).
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Data_Valid,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  parity_enable,
  input  logic                  Parity_Type,
  input  logic                  stop_two,
  output logic                  busy,
  output logic                  TX_OUT,
  output logic                  tx_done
);

  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_WIDTH - 1);

  tx_state_t             state, state_nxt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic                  par_bit, par_bit_nxt;
  logic                  par_en, par_en_nxt;
  logic                  two_stop, two_stop_nxt;
  logic                  tx_q, tx_nxt;
  logic                  done;
  logic                  bit_tick;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .enable  (state != IDLE),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift;
    idx_nxt      = idx;
    par_bit_nxt  = par_bit;
    par_en_nxt   = par_en;
    two_stop_nxt = two_stop;
    done         = 1'b0;
    tx_nxt       = IDLE_LEVEL;

    case (state)
      IDLE: begin
        if (Data_Valid) begin
          state_nxt    = START;
          shift_nxt    = P_Data;
          par_bit_nxt  = parity_bit(9'(P_Data), Parity_Type);
          par_en_nxt   = parity_enable;
          two_stop_nxt = stop_two;
        end
      end
      START: begin
        if (bit_tick) state_nxt = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          if (idx == LAST_DATA) begin
            state_nxt = par_en ? PARITY : STOP;
          end else begin
            idx_nxt   = idx + IW'(1);
            shift_nxt = shift >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_tick) state_nxt = STOP;
      end
      STOP: begin
        // idx counts completed stop bits; the last one is index 0 or 1.
        if (bit_tick) begin
          if (idx == IW'(two_stop)) begin
            state_nxt = IDLE;
            done      = 1'b1;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state) idx_nxt = '0;

    // Line level is computed for the upcoming state so TX_OUT is a plain flop.
    case (state_nxt)
      START:   tx_nxt = START_LEVEL;
      DATA:    tx_nxt = shift_nxt[0];
      PARITY:  tx_nxt = par_bit_nxt;
      default: tx_nxt = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      shift    <= '0;
      idx      <= '0;
      par_bit  <= 1'b0;
      par_en   <= 1'b0;
      two_stop <= 1'b0;
      tx_q     <= IDLE_LEVEL;
    end else begin
      state    <= state_nxt;
      shift    <= shift_nxt;
      idx      <= idx_nxt;
      par_bit  <= par_bit_nxt;
      par_en   <= par_en_nxt;
      two_stop <= two_stop_nxt;
      tx_q     <= tx_nxt;
    end
  end

  assign TX_OUT  = tx_q;
  assign busy    = (state != IDLE);
  assign tx_done = done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: two instances (8-bit/4 clk per bit, 5-bit/1 clk per bit)
// checked cycle by cycle against a frame-level bit-list model.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv8, dv5;
  logic [7:0] pd;
  logic       pe, pt, st;
  logic       busy8, tx8, done8;
  logic       busy5, tx5, done5;

  int errors = 0;
  int checks = 0;

  bit mbits[0:15];
  int mn;

  typedef struct {
    bit         s5;
    logic [7:0] d;
    bit         pe;
    bit         pt;
    bit         st;
    int         mode;
    int         exp_len;
    bit         exp_par;
  } vec_t;

  vec_t tbl[8];

  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut8 (
    .clk(clk), .rst(rst), .Data_Valid(dv8), .P_Data(pd),
    .parity_enable(pe), .Parity_Type(pt), .stop_two(st),
    .busy(busy8), .TX_OUT(tx8), .tx_done(done8)
  );

  uart_tx_frame #(.DATA_WIDTH(5), .CLKS_PER_BIT(1)) dut5 (
    .clk(clk), .rst(rst), .Data_Valid(dv5), .P_Data(pd[4:0]),
    .parity_enable(pe), .Parity_Type(pt), .stop_two(st),
    .busy(busy5), .TX_OUT(tx5), .tx_done(done5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Line-level bit list of one frame, straight from the framing rules.
  task automatic build(input int w, input logic [8:0] d, input bit pe_i, input bit pt_i, input bit st_i);
    int ones;
    ones = 0;
    mn = 0;
    mbits[mn] = 1'b0; mn = mn + 1;
    for (int i = 0; i < w; i++) begin
      mbits[mn] = d[i]; mn = mn + 1;
      ones = ones + int'(d[i]);
    end
    if (pe_i) begin
      mbits[mn] = ((ones % 2) == 1) ^ pt_i; mn = mn + 1;
    end
    mbits[mn] = 1'b1; mn = mn + 1;
    if (st_i) begin
      mbits[mn] = 1'b1; mn = mn + 1;
    end
  endtask

  task automatic start(input bit s5, input logic [7:0] d, input bit pe_i, input bit pt_i, input bit st_i);
    pd = d; pe = pe_i; pt = pt_i; st = st_i;
    dv8 = !s5;
    dv5 = s5;
  endtask

  // mode 0: drop Data_Valid; 1: also scramble data/config every cycle;
  // 2: hold Data_Valid, present 0xFF mid-frame, then nxt for the following frame.
  task automatic check_frame(input bit s5, input int w, input int c, input logic [7:0] d,
                             input bit pe_i, input bit pt_i, input bit st_i, input int mode,
                             input logic [7:0] nxt, input int max_k,
                             output int bcnt, output logic pseen);
    int L;
    logic t, b, dn;
    build(w, {1'b0, d}, pe_i, pt_i, st_i);
    L = mn * c;
    bcnt = 0;
    pseen = 1'b0;
    for (int k = 0; k < L && k < max_k; k++) begin
      @(negedge clk);
      t  = s5 ? tx5 : tx8;
      b  = s5 ? busy5 : busy8;
      dn = s5 ? done5 : done8;
      if (b) bcnt++;
      if (k == (1 + w) * c) pseen = t;
      chk($sformatf("w%0d d=%0h cyc%0d {tx,busy,done}", w, d, k + 1),
          32'({t, b, dn}), 32'({mbits[k / c], 1'b1, k == L - 1}));
      if (mode == 0 || mode == 1) begin
        dv8 = 1'b0;
        dv5 = 1'b0;
      end
      if (mode == 1) begin
        pd = 8'($urandom);
        pt = ~pt;
        st = ~st;
        pe = ~pe;
      end
      if (mode == 2) begin
        if (k == 0) pd = 8'hFF;
        if (k == L / 2) pd = nxt;
      end
    end
  endtask

  task automatic check_idle(input string nm);
    @(negedge clk);
    chk({nm, " idle {tx8,busy8,done8,tx5,busy5,done5}"},
        32'({tx8, busy8, done8, tx5, busy5, done5}), 32'(6'b100100));
  endtask

  initial begin
    int   bc;
    logic ps;
    bit   s5;
    int   w, c, mode;

    tbl[0] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 0, 44, 1'b0};
    tbl[1] = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 0, 48, 1'b1};
    tbl[2] = '{1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 0,  7, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 44, 1'b1};
    tbl[4] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 0, 44, 1'b0};
    tbl[5] = '{1'b1, 8'h1F, 1'b1, 1'b0, 1'b1, 0,  9, 1'b1};
    tbl[6] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 0,  8, 1'b0};
    tbl[7] = '{1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, 1, 44, 1'b1};

    rst = 1'b0; dv8 = 1'b1; dv5 = 1'b1; pd = 8'h00; pe = 1'b0; pt = 1'b0; st = 1'b0;
    repeat (3) @(negedge clk);
    chk("in reset {tx8,busy8,done8,tx5,busy5,done5}",
        32'({tx8, busy8, done8, tx5, busy5, done5}), 32'(6'b100100));
    rst = 1'b1; dv8 = 1'b0; dv5 = 1'b0;
    check_idle("after reset");

    for (int i = 0; i < 8; i++) begin
      w = tbl[i].s5 ? 5 : 8;
      c = tbl[i].s5 ? 1 : 4;
      start(tbl[i].s5, tbl[i].d, tbl[i].pe, tbl[i].pt, tbl[i].st);
      check_frame(tbl[i].s5, w, c, tbl[i].d, tbl[i].pe, tbl[i].pt, tbl[i].st,
                  tbl[i].mode, 8'h00, 1000, bc, ps);
      chk($sformatf("vec%0d busy length", i), 32'(bc), 32'(tbl[i].exp_len));
      if (tbl[i].pe) chk($sformatf("vec%0d parity bit", i), 32'(ps), 32'(tbl[i].exp_par));
      check_idle($sformatf("vec%0d", i));
    end

    // Back-to-back with Data_Valid held; 0xFF presented mid-frame must not be sent.
    start(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    check_frame(1'b0, 8, 4, 8'h3C, 1'b0, 1'b0, 1'b0, 2, 8'hC3, 1000, bc, ps);
    chk("b2b frame1 busy length", 32'(bc), 32'd40);
    check_idle("b2b gap");
    check_frame(1'b0, 8, 4, 8'hC3, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1000, bc, ps);
    chk("b2b frame2 busy length", 32'(bc), 32'd40);
    check_idle("b2b end");

    // Reset in the DATA state, with Data_Valid high in the same cycle.
    start(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
    check_frame(1'b0, 8, 4, 8'hA5, 1'b1, 1'b0, 1'b0, 0, 8'h00, 10, bc, ps);
    rst = 1'b0; dv8 = 1'b1;
    @(negedge clk);
    chk("mid-frame reset {tx,busy,done}", 32'({tx8, busy8, done8}), 32'(3'b100));
    rst = 1'b1; dv8 = 1'b0;
    repeat (6) check_idle("post reset");

    for (int n = 0; n < 24; n++) begin
      s5   = bit'($urandom_range(0, 1));
      w    = s5 ? 5 : 8;
      c    = s5 ? 1 : 4;
      mode = int'($urandom_range(0, 1));
      start(s5, 8'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)));
      check_frame(s5, w, c, pd, pe, pt, st, mode, 8'h00, 1000, bc, ps);
      chk($sformatf("rand%0d busy length", n), 32'(bc), 32'(mn * c));
      check_idle($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
